// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner. It drives one shared active-low segment bus
// and one active-low anode per digit. Features: hex decode, per-digit decimal
// point and blanking, PWM brightness, and shadow registers that update only at
// a frame boundary so a frame never shows a mix of old and new digits.
module seg_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_TICKS = 400000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int TICK_W = $clog2(DIGIT_TICKS);
    localparam int DIG_W  = $clog2(NUM_DIGITS);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0] GUARD_TICKS = TICK_W'(2);
    localparam logic [DIG_W-1:0]  DIG_LEFT    = DIG_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]       tick_cnt;
    logic [DIG_W-1:0]        digit_idx;
    logic [BRIGHT_W-1:0]     pwm_cnt;

    logic [4*NUM_DIGITS-1:0] value_act;
    logic [NUM_DIGITS-1:0]   dp_act;
    logic [NUM_DIGITS-1:0]   blank_act;
    logic [4*NUM_DIGITS-1:0] value_pend;
    logic [NUM_DIGITS-1:0]   dp_pend;
    logic [NUM_DIGITS-1:0]   blank_pend;
    logic                    pend_flag;

    logic                    frame_end;
    logic [3:0]              nibble;
    logic                    anode_on;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    frame_start_next;

    // This is the last cycle of the rightmost slot. Shadow registers hand over here.
    assign frame_end = (tick_cnt == TICK_LAST) && (digit_idx == '0);

    // Slot timer, digit scan (leftmost first) and free-running PWM counter.
    // digit_idx resets to the leftmost digit so scanning restarts at the left.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so that every flop
        // samples pre-edge values and the result does not depend on block order.
        if (rst) begin
            tick_cnt  <= '0;
            digit_idx <= DIG_LEFT;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
            if (tick_cnt == TICK_LAST) begin
                tick_cnt  <= '0;
                digit_idx <= (digit_idx == '0) ? DIG_LEFT : digit_idx - DIG_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

    // Pending/active shadow registers. A load in the boundary cycle goes straight
    // to the active registers and discards any older pending value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_act  <= '0;
            dp_act     <= '0;
            blank_act  <= '0;
            value_pend <= '0;
            dp_pend    <= '0;
            blank_pend <= '0;
            pend_flag  <= 1'b0;
        end else begin
            if (load && !frame_end) begin
                value_pend <= value_in;
                dp_pend    <= dp_in;
                blank_pend <= blank_in;
                pend_flag  <= 1'b1;
            end
            if (frame_end) begin
                if (load) begin
                    value_act <= value_in;
                    dp_act    <= dp_in;
                    blank_act <= blank_in;
                    pend_flag <= 1'b0;
                end else if (pend_flag) begin
                    value_act <= value_pend;
                    dp_act    <= dp_pend;
                    blank_act <= blank_pend;
                    pend_flag <= 1'b0;
                end
            end
        end
    end

    // Next output values for the current slot: anode gating, hex decode, decimal point.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave a signal
        // unassigned and infer a latch.
        an_next          = '1;
        seg_next         = 7'h7F;
        dp_next          = 1'b1;
        nibble           = value_act[{digit_idx, 2'b00} +: 4];
        anode_on         = !blank_act[digit_idx] && (pwm_cnt <= brightness)
                           && (tick_cnt >= GUARD_TICKS);
        frame_start_next = (tick_cnt == '0) && (digit_idx == DIG_LEFT);

        if (anode_on) begin
            an_next[digit_idx] = 1'b0;
            dp_next            = ~dp_act[digit_idx];
            case (nibble)
                4'h0:    seg_next = 7'b0000001;
                4'h1:    seg_next = 7'b1001111;
                4'h2:    seg_next = 7'b0010010;
                4'h3:    seg_next = 7'b0000110;
                4'h4:    seg_next = 7'b1001100;
                4'h5:    seg_next = 7'b0100100;
                4'h6:    seg_next = 7'b0100000;
                4'h7:    seg_next = 7'b0001111;
                4'h8:    seg_next = 7'b0000000;
                4'h9:    seg_next = 7'b0000100;
                4'hA:    seg_next = 7'b0001000;
                4'hB:    seg_next = 7'b1100000;
                4'hC:    seg_next = 7'b0110001;
                4'hD:    seg_next = 7'b1000010;
                4'hE:    seg_next = 7'b0110000;
                default: seg_next = 7'b0111000;
            endcase
        end
    end

    // Registered pin drivers. They follow the counter state one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            seg         <= seg_next;
            dp          <= dp_next;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with 4 digits, 32-cycle slots and 4-bit brightness.
// A reference model pushes the expected pin state each clock. A checker pops
// the entry on the falling edge and compares it. Directed frame checks use
// values from a decode table.
module tb_seg_scan_display;

    localparam int ND     = 4;
    localparam int TICKS  = 32;
    localparam int BW     = 4;
    localparam int FRAME  = ND * TICKS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          load = 1'b0;
    logic [BW-1:0] brightness = '1;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    seg_scan_display #(
        .NUM_DIGITS (ND),
        .DIGIT_TICKS(TICKS),
        .BRIGHT_W   (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Decode vectors: nibble and the expected active-low abcdefg pattern.
    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } dec_vec_t;
    dec_vec_t dec_tab [16];

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } out_t;

    typedef struct {
        int         tick;
        int         digit;
        int         pwm;
        logic [15:0] val;
        logic [3:0]  dpa;
        logic [3:0]  bla;
        logic [15:0] pval;
        logic [3:0]  pdp;
        logic [3:0]  pbl;
        bit          pflag;
    } mstate_t;

    mstate_t ms;
    out_t    sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] r;
        r = 7'h7F;
        for (int i = 0; i < 16; i++)
            if (dec_tab[i].nib == n) r = dec_tab[i].seg;
        return r;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s.tick = 0; s.digit = ND - 1; s.pwm = 0;
        s.val = '0; s.dpa = '0; s.bla = '0;
        s.pval = '0; s.pdp = '0; s.pbl = '0; s.pflag = 1'b0;
        return s;
    endfunction

    function automatic out_t model_out(input mstate_t s, input logic [BW-1:0] br);
        out_t e;
        bit   lit;
        lit  = !s.bla[s.digit] && (s.pwm <= int'(br)) && (s.tick >= 2);
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        if (lit) begin
            e.an[s.digit] = 1'b0;
            e.seg = decode(s.val[s.digit*4 +: 4]);
            e.dp  = !s.dpa[s.digit];
        end
        e.fs = (s.tick == 0) && (s.digit == ND - 1);
        return e;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic ld, input logic [15:0] v,
                                           input logic [3:0] d, input logic [3:0] b);
        mstate_t n;
        bit      boundary;
        n = s;
        boundary = (s.tick == TICKS - 1) && (s.digit == 0);
        if (ld && boundary) begin
            n.val = v; n.dpa = d; n.bla = b; n.pflag = 1'b0;
        end else if (ld) begin
            n.pval = v; n.pdp = d; n.pbl = b; n.pflag = 1'b1;
        end else if (boundary && s.pflag) begin
            n.val = s.pval; n.dpa = s.pdp; n.bla = s.pbl; n.pflag = 1'b0;
        end
        n.pwm = (s.pwm + 1) % (1 << BW);
        if (s.tick == TICKS - 1) begin
            n.tick  = 0;
            n.digit = (s.digit == 0) ? ND - 1 : s.digit - 1;
        end else begin
            n.tick = s.tick + 1;
        end
        return n;
    endfunction

    // Reference model: push the expected registered outputs, then advance the model state.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms <= model_reset();
            sb_q.delete();
        end else begin
            sb_q.push_back(model_out(ms, brightness));
            ms <= model_step(ms, load, value_in, dp_in, blank_in);
        end
    end

    // Scoreboard checker: compare the DUT pins with the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && sb_q.size() > 0)
            check("scoreboard {an,seg,dp,fs}", {19'd0, an, seg, dp, frame_start}, {19'd0, sb_q.pop_front()});
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        #1;
        value_in = v; dp_in = d; blank_in = b; load = 1'b1;
        @(negedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_fs(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 3 * FRAME);
        check({name, " frame_start seen"}, 32'(frame_start), 32'd1);
    endtask

    // Called at the frame_start cycle. Samples the middle of each slot, leftmost
    // first. It can issue one load right after the slot given by load_slot.
    task automatic check_frame(input string name, input logic [15:0] v,
                               input int load_slot, input logic [15:0] lv);
        int         gap;
        logic [3:0] ea;
        gap = TICKS / 2;
        for (int s = ND - 1; s >= 0; s--) begin
            repeat (gap) @(negedge clk);
            ea    = 4'hF;
            ea[s] = 1'b0;
            check({name, " an"},  32'(an),  32'(ea));
            check({name, " seg"}, 32'(seg), 32'(decode(v[4*s +: 4])));
            check({name, " dp"},  32'(dp),  32'd1);
            gap = TICKS;
            if (s == load_slot) begin
                do_load(lv, 4'h0, 4'h0);
                gap = TICKS - 1;
            end
        end
    endtask

    // Called at the frame_start cycle. Counts lit cycles over one whole frame.
    task automatic count_frame(output int on_cnt, output logic [3:0] low_mask,
                               output logic dp_left, output logic dp_d1);
        on_cnt = 0; low_mask = '0; dp_left = 1'bx; dp_d1 = 1'bx;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (an != 4'hF) on_cnt++;
            low_mask = low_mask | ~an;
            if (c == TICKS / 2)             dp_left = dp;
            if (c == 2 * TICKS + TICKS / 2) dp_d1   = dp;
        end
    endtask

    initial begin
        int         n;
        int         on_cnt;
        logic [3:0] mask;
        logic       dpl, dp1;

        dec_tab[0]  = '{4'h0, 7'b0000001}; dec_tab[1]  = '{4'h1, 7'b1001111};
        dec_tab[2]  = '{4'h2, 7'b0010010}; dec_tab[3]  = '{4'h3, 7'b0000110};
        dec_tab[4]  = '{4'h4, 7'b1001100}; dec_tab[5]  = '{4'h5, 7'b0100100};
        dec_tab[6]  = '{4'h6, 7'b0100000}; dec_tab[7]  = '{4'h7, 7'b0001111};
        dec_tab[8]  = '{4'h8, 7'b0000000}; dec_tab[9]  = '{4'h9, 7'b0000100};
        dec_tab[10] = '{4'hA, 7'b0001000}; dec_tab[11] = '{4'hB, 7'b1100000};
        dec_tab[12] = '{4'hC, 7'b0110001}; dec_tab[13] = '{4'hD, 7'b1000010};
        dec_tab[14] = '{4'hE, 7'b0110000}; dec_tab[15] = '{4'hF, 7'b0111000};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset an",  32'(an),          32'hF);
        check("reset seg", 32'(seg),         32'h7F);
        check("reset dp",  32'(dp),          32'd1);
        check("reset fs",  32'(frame_start), 32'd0);
        #1 rst = 1'b0;

        wait_fs("post-reset", n);
        check("leftmost slot right after reset", 32'(n), 32'd1);
        check_frame("reset zeros", 16'h0000, -1, 16'h0);

        // All 16 decode patterns, one frame each
        for (int i = 0; i < 16; i++) begin
            do_load({4{dec_tab[i].nib}}, 4'h0, 4'h0);
            wait_fs("decode", n);
            check_frame($sformatf("decode %h", dec_tab[i].nib), {4{dec_tab[i].nib}}, -1, 16'h0);
        end

        // 4291, with ABCD loaded mid-frame. The current frame must not tear.
        do_load(16'h4291, 4'h0, 4'h0);
        wait_fs("4291", n);
        check_frame("4291", 16'h4291, 2, 16'hABCD);
        wait_fs("ABCD", n);
        check_frame("ABCD", 16'hABCD, -1, 16'h0);

        // Load in the exact boundary cycle wins over an older pending value
        wait_fs("pre-boundary", n);
        do_load(16'h7777, 4'h0, 4'h0);
        repeat (FRAME - 3) @(negedge clk);
        #1 value_in = 16'h0000; load = 1'b1;
        @(negedge clk);
        #1 load = 1'b0;
        wait_fs("boundary", n);
        check("boundary frame_start timing", 32'(n), 32'd1);
        check_frame("boundary load", 16'h0000, -1, 16'h0);
        wait_fs("discard", n);
        check_frame("pending discarded", 16'h0000, -1, 16'h0);

        // Blanking and decimal point
        do_load(16'h4291, 4'b1000, 4'b0101);
        wait_fs("blank", n);
        count_frame(on_cnt, mask, dpl, dp1);
        check("blank lit cycles", 32'(on_cnt), 32'd60);
        check("blank anode mask", 32'(mask), 32'(4'b1010));
        check("leftmost dp lit",  32'(dpl),  32'd0);
        check("digit1 dp dark",   32'(dp1),  32'd1);

        // Brightness 0 and 7
        wait_fs("bright0 pre", n);
        #1 brightness = 4'd0;
        do_load(16'h4291, 4'h0, 4'h0);
        wait_fs("bright0", n);
        count_frame(on_cnt, mask, dpl, dp1);
        check("brightness 0 lit cycles", 32'(on_cnt), 32'd4);
        check("brightness 0 anode mask", 32'(mask),   32'hF);
        #1 brightness = 4'd7;
        wait_fs("bright7", n);
        count_frame(on_cnt, mask, dpl, dp1);
        check("brightness 7 lit cycles", 32'(on_cnt), 32'd56);
        #1 brightness = 4'hF;

        // Asynchronous reset in the middle of a slot
        wait_fs("pre-reset", n);
        repeat (20) @(negedge clk);
        check("lit before reset", 32'(an), 32'(4'b0111));
        #1 rst = 1'b1;
        #1;
        check("async reset an",  32'(an),  32'hF);
        check("async reset seg", 32'(seg), 32'h7F);
        check("async reset dp",  32'(dp),  32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        wait_fs("after reset", n);
        check("after reset leftmost first", 32'(n), 32'd1);
        check_frame("after reset zeros", 16'h0000, -1, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
